// File: rtl/brick_scroll_ctrl_if.sv
// Brick ground scroller bundle: pixel coordinates and game pulses into the
// controller, sprite lookup coordinates and scroll/FSM status out of it.
interface brick_scroll_ctrl_if;
  logic [10:0] pix_x;
  logic [10:0] pix_y;
  logic        frame_tick;
  logic        game_start;
  logic        game_over;
  logic        pause_tog;
  logic [10:0] tile_x;
  logic [10:0] tile_y;
  logic        ground_vld;
  logic [3:0]  scroll_ofs;
  logic [2:0]  speed;
  logic [1:0]  state;

  // Video/game side: drives pixels and pulses, observes sprite coordinates.
  modport master (
    output pix_x, pix_y, frame_tick, game_start, game_over, pause_tog,
    input  tile_x, tile_y, ground_vld, scroll_ofs, speed, state
  );

  // Controller side.
  modport slave (
    input  pix_x, pix_y, frame_tick, game_start, game_over, pause_tog,
    output tile_x, tile_y, ground_vld, scroll_ofs, speed, state
  );
endinterface

// File: rtl/brick_scroll_ctrl.sv
// Brick ground strip scroll controller.
// Game FSM (IDLE/RUN/PAUSE/DEAD), per-frame horizontal scroll offset, and a
// two-stage pixel pipeline that maps screen pixels onto brick tile
// coordinates for a sprite with a registered row lookup.
// Optional macro BRICK_SCROLL_ACCEL_EN: speed steps up every 256 RUN frames,
// saturating at SPEED_MAX; otherwise speed is fixed at SPEED_INIT.
module brick_scroll_ctrl #(
  parameter logic [10:0] GROUND_TOP = 11'd448,
  parameter logic [10:0] GROUND_BOT = 11'd480,
  parameter logic [2:0]  SPEED_INIT = 3'd1,
  parameter logic [2:0]  SPEED_MAX  = 3'd4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  brick_scroll_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DEAD  = 2'b11
  } state_t;

  localparam logic [10:0] TILE_OFF = 11'd16;  // sprite mask is 0 here

  state_t      state_reg, state_next;
  logic        load_run;          // entering RUN from IDLE/DEAD
  logic        run_tick;          // a frame advances the scroll
  logic [3:0]  scroll_ofs_reg;
  logic [2:0]  speed_cur;

  logic        in_strip;
  logic [10:0] row_rel;
  logic        s1_strip_reg;
  logic [3:0]  s1_pix_x_reg;
  logic [3:0]  s1_ofs_reg;
  logic [10:0] tile_y_reg;
  logic [3:0]  col_sum;
  logic [10:0] tile_x_reg;
  logic        ground_vld_reg;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state: game_over beats game_start beats pause_tog.
  always_comb begin
    state_next = state_reg;
    load_run   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.game_start) begin
          state_next = RUN;
          load_run   = 1'b1;
        end
      end
      RUN: begin
        if (bus.game_over)      state_next = DEAD;
        else if (bus.pause_tog) state_next = PAUSE;
      end
      PAUSE: begin
        if (bus.game_over)      state_next = DEAD;
        else if (bus.pause_tog) state_next = RUN;
      end
      DEAD: begin
        if (bus.game_start) begin
          state_next = RUN;
          load_run   = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign run_tick = bus.frame_tick && (state_reg == RUN);

  // Scroll offset: advances by speed each RUN frame, 4-bit wrap.
  always_ff @(posedge clk) begin
    if (!rst_n)        scroll_ofs_reg <= 4'd0;
    else if (load_run) scroll_ofs_reg <= 4'd0;
    else if (run_tick) scroll_ofs_reg <= scroll_ofs_reg + {1'b0, speed_cur};
  end

`ifdef BRICK_SCROLL_ACCEL_EN
  logic [7:0] frame_cnt_reg;
  logic [2:0] speed_reg;

  // Frame counter and speed ramp: one step per 256 RUN frames.
  always_ff @(posedge clk) begin
    if (!rst_n || load_run) begin
      frame_cnt_reg <= 8'd0;
      speed_reg     <= SPEED_INIT;
    end else if (run_tick) begin
      frame_cnt_reg <= frame_cnt_reg + 8'd1;
      if (frame_cnt_reg == 8'hFF && speed_reg < SPEED_MAX)
        speed_reg <= speed_reg + 3'd1;
    end
  end

  assign speed_cur = speed_reg;
`else
  assign speed_cur = SPEED_INIT;
`endif

  assign in_strip = (bus.pix_y >= GROUND_TOP) && (bus.pix_y < GROUND_BOT);
  assign row_rel  = bus.pix_y - GROUND_TOP;

  // Stage 1: row lookup, and capture column/offset for the column stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_strip_reg <= 1'b0;
      s1_pix_x_reg <= 4'd0;
      s1_ofs_reg   <= 4'd0;
      tile_y_reg   <= TILE_OFF;
    end else begin
      s1_strip_reg <= in_strip;
      s1_pix_x_reg <= bus.pix_x[3:0];
      s1_ofs_reg   <= scroll_ofs_reg;
      tile_y_reg   <= in_strip ? {7'd0, row_rel[3:0]} : TILE_OFF;
    end
  end

  // Offset is taken from stage 1, so a later scroll change cannot reach back.
  assign col_sum = s1_pix_x_reg + s1_ofs_reg;

  // Stage 2: scrolled column, valid lines up with the sprite's row read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tile_x_reg     <= TILE_OFF;
      ground_vld_reg <= 1'b0;
    end else begin
      tile_x_reg     <= s1_strip_reg ? {7'd0, col_sum} : TILE_OFF;
      ground_vld_reg <= s1_strip_reg;
    end
  end

  assign bus.tile_x     = tile_x_reg;
  assign bus.tile_y     = tile_y_reg;
  assign bus.ground_vld = ground_vld_reg;
  assign bus.scroll_ofs = scroll_ofs_reg;
  assign bus.speed      = speed_cur;
  assign bus.state      = state_reg;

endmodule

// File: tb/tb_brick_scroll_ctrl.sv
// Directed bench for brick_scroll_ctrl: FSM, scroll wrap, pixel pipeline,
// reset behaviour and speed (BRICK_SCROLL_ACCEL_EN selects the ramp checks).
module tb_brick_scroll_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  brick_scroll_ctrl_if bus();

  brick_scroll_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Advance one clock, then sample 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("check %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic frame();
    bus.frame_tick = 1'b1;
    tick();
    bus.frame_tick = 1'b0;
  endtask

  initial begin
    bus.pix_x = 11'd0;
    bus.pix_y = 11'd100;
    bus.frame_tick = 1'b0;
    bus.game_start = 1'b0;
    bus.game_over = 1'b0;
    bus.pause_tog = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_state", bus.state, 11'd0);
    chk("rst_ofs", bus.scroll_ofs, 11'd0);
    chk("rst_speed", bus.speed, 11'd1);
    chk("rst_tile_x", bus.tile_x, 11'd16);
    chk("rst_tile_y", bus.tile_y, 11'd16);
    chk("rst_vld", bus.ground_vld, 11'd0);
    rst_n = 1'b1;
    tick();

    // Frame ticks in IDLE are ignored
    frame();
    chk("idle_hold_ofs", bus.scroll_ofs, 11'd0);

    // Start and three frames at speed 1
    bus.game_start = 1'b1; tick(); bus.game_start = 1'b0;
    chk("start_state", bus.state, 11'd1);
    frame(); frame(); frame();
    chk("run3_ofs", bus.scroll_ofs, 11'd3);

    // Pipeline: strip pixel then off-strip pixel
    bus.pix_y = 11'd450; bus.pix_x = 11'd5;
    tick();
    chk("p1_tile_y", bus.tile_y, 11'd2);
    bus.pix_y = 11'd100; bus.pix_x = 11'd0;
    tick();
    chk("p2_tile_x", bus.tile_x, 11'd8);
    chk("p2_vld", bus.ground_vld, 11'd1);
    chk("off_tile_y", bus.tile_y, 11'd16);
    tick();
    chk("off_tile_x", bus.tile_x, 11'd16);
    chk("off_vld", bus.ground_vld, 11'd0);

    // Strip edges and column wrap
    bus.pix_y = 11'd447; tick();
    chk("y447_tile_y", bus.tile_y, 11'd16);
    bus.pix_y = 11'd448; bus.pix_x = 11'd14; tick();
    chk("y448_tile_y", bus.tile_y, 11'd0);
    chk("y447_vld", bus.ground_vld, 11'd0);
    bus.pix_y = 11'd479; bus.pix_x = 11'd0; tick();
    chk("y479_tile_y", bus.tile_y, 11'd15);
    chk("x14_wrap_tile_x", bus.tile_x, 11'd1);
    chk("y448_vld", bus.ground_vld, 11'd1);
    bus.pix_y = 11'd480; tick();
    chk("y480_tile_y", bus.tile_y, 11'd16);
    chk("y479_tile_x", bus.tile_x, 11'd3);
    tick();
    chk("y480_vld", bus.ground_vld, 11'd0);

    // Offset change after sampling does not reach pixels already in flight
    bus.pix_y = 11'd450; bus.pix_x = 11'd5;
    tick();
    bus.pix_y = 11'd100;
    frame();
    chk("inflight_tile_x", bus.tile_x, 11'd8);
    chk("inflight_ofs", bus.scroll_ofs, 11'd4);

    // Pause holds scroll, game_start in RUN ignored
    bus.pause_tog = 1'b1; tick(); bus.pause_tog = 1'b0;
    chk("pause_state", bus.state, 11'd2);
    frame();
    chk("pause_hold_ofs", bus.scroll_ofs, 11'd4);
    bus.pause_tog = 1'b1; tick(); bus.pause_tog = 1'b0;
    chk("resume_state", bus.state, 11'd1);
    bus.game_start = 1'b1; tick(); bus.game_start = 1'b0;
    chk("start_in_run_state", bus.state, 11'd1);
    chk("start_in_run_ofs", bus.scroll_ofs, 11'd4);

    // Wrap 15 -> 0
    for (int i = 0; i < 11; i++) frame();
    chk("ofs15", bus.scroll_ofs, 11'd15);
    frame();
    chk("wrap_ofs", bus.scroll_ofs, 11'd0);

    // game_over beats pause_tog, DEAD holds, restart reloads
    frame(); frame();
    bus.game_over = 1'b1; bus.pause_tog = 1'b1; tick();
    bus.game_over = 1'b0; bus.pause_tog = 1'b0;
    chk("dead_state", bus.state, 11'd3);
    frame(); frame();
    chk("dead_hold_ofs", bus.scroll_ofs, 11'd2);
    bus.game_start = 1'b1; tick(); bus.game_start = 1'b0;
    chk("restart_state", bus.state, 11'd1);
    chk("restart_ofs", bus.scroll_ofs, 11'd0);

    // Reset in RUN with offset 7 and a strip pixel in flight
    for (int i = 0; i < 7; i++) frame();
    chk("ofs7", bus.scroll_ofs, 11'd7);
    bus.pix_y = 11'd450; tick(); tick();
    chk("pre_rst_vld", bus.ground_vld, 11'd1);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("rst_run_state", bus.state, 11'd0);
    chk("rst_run_ofs", bus.scroll_ofs, 11'd0);
    chk("rst_run_vld", bus.ground_vld, 11'd0);
    tick();
    chk("post_rst1_vld", bus.ground_vld, 11'd0);
    tick();
    chk("post_rst2_vld", bus.ground_vld, 11'd1);
    bus.pix_y = 11'd100;

    // Speed behaviour over many RUN frames
    bus.game_start = 1'b1; tick(); bus.game_start = 1'b0;
`ifdef BRICK_SCROLL_ACCEL_EN
    for (int i = 0; i < 255; i++) frame();
    chk("spd_255", bus.speed, 11'd1);
    frame();
    chk("spd_256", bus.speed, 11'd2);
    for (int i = 0; i < 768; i++) frame();
    chk("spd_1024", bus.speed, 11'd4);
    for (int i = 0; i < 256; i++) frame();
    chk("spd_sat", bus.speed, 11'd4);
`else
    for (int i = 0; i < 300; i++) frame();
    chk("spd_const", bus.speed, 11'd1);
    chk("ofs_300", bus.scroll_ofs, 11'd12);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
